// File: rtl/sprite_line_scheduler.sv
// Builds one scanline: clears the line buffer, then paints sprite slots 2,1,0 from a shared ROM.
// Optional build macro SPRITE_TRANSPARENCY_EN skips black (24'h000000) sprite pixels.
module sprite_line_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int ROM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [9:0]  line_y,
  input  logic [31:0] sprite0,
  input  logic [31:0] sprite1,
  input  logic [31:0] sprite2,
  output logic [9:0]  rom_addr,
  output logic [1:0]  rom_sel,
  input  logic [23:0] rom_data,
  output logic        wr_en,
  output logic [9:0]  wr_addr,
  output logic [23:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        overrun
);
  typedef struct packed {
    logic [6:0] dim;
    logic [4:0] id;
    logic [9:0] y;
    logic [9:0] x;
  } sprite_t;

  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, FETCH, DRAIN, FIN} state_t;

  state_t                 state;
  sprite_t [2:0]          spr;
  logic [9:0]             ly;
  logic [9:0]             cnt;
  logic [1:0]             slot;
  logic [6:0]             cur_dim;
  logic [ROM_LAT:0]       vld_pipe;
  logic [ROM_LAT:0][10:0] wa_pipe;

  // Eligibility and ROM base address of the slot under SCAN
  sprite_t     cs;
  logic [10:0] ly_w, y_lo, y_hi;
  logic        id_ok, elig;
  logic [1:0]  sel;
  logic [9:0]  row, base;

  always_comb begin
    cs    = spr[slot];
    ly_w  = {1'b0, ly};
    y_lo  = {1'b0, cs.y};
    y_hi  = y_lo + {4'd0, cs.dim} - 11'd1;
    id_ok = (cs.id == 5'd0) || (cs.id == 5'd2) || (cs.id == 5'd3);
    elig  = (cs.dim != 7'd0) && id_ok && (ly_w >= y_lo) && (ly_w <= y_hi);
    sel   = (cs.id == 5'd0) ? 2'd0 : (cs.id == 5'd2) ? 2'd1 : 2'd2;
    row   = ly - cs.y;
    base  = row * {3'd0, cs.dim};
  end

  // Write port: CLEAR owns it outright; otherwise the oldest pipe stage writes ROM data
  logic pix_ok;

  always_comb begin
    pix_ok = vld_pipe[ROM_LAT] && (wa_pipe[ROM_LAT] < 11'(H_ACTIVE));
`ifdef SPRITE_TRANSPARENCY_EN
    pix_ok = pix_ok && (rom_data != 24'h000000);
`endif
    wr_en   = (state == CLEAR) || pix_ok;
    wr_addr = (state == CLEAR) ? cnt : (pix_ok ? wa_pipe[ROM_LAT][9:0] : 10'd0);
    wr_data = pix_ok ? rom_data : 24'h000000;
    busy    = (state == CLEAR) || (state == SCAN) || (state == FETCH) || (state == DRAIN);
    done    = (state == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      spr      <= '0;
      ly       <= '0;
      cnt      <= '0;
      slot     <= '0;
      cur_dim  <= '0;
      rom_addr <= '0;
      rom_sel  <= '0;
      overrun  <= 1'b0;
      vld_pipe <= '0;
      wa_pipe  <= '0;
    end else begin
      overrun                <= 1'b0;
      vld_pipe[ROM_LAT:1]    <= vld_pipe[ROM_LAT-1:0];
      wa_pipe[ROM_LAT:1]     <= wa_pipe[ROM_LAT-1:0];
      if (line_start) begin
        // Restart always wins; flushing the pipe drops reads of the aborted line
        overrun  <= busy;
        ly       <= line_y;
        spr      <= {sprite2, sprite1, sprite0};
        state    <= CLEAR;
        cnt      <= '0;
        vld_pipe <= '0;
      end else begin
        vld_pipe[0] <= 1'b0;
        case (state)
          IDLE: state <= IDLE;
          CLEAR: begin
            if (cnt == 10'(H_ACTIVE - 1)) begin
              state <= SCAN;
              slot  <= 2'd2;
            end else begin
              cnt <= cnt + 10'd1;
            end
          end
          SCAN: begin
            if (elig) begin
              state       <= FETCH;
              cnt         <= '0;
              cur_dim     <= cs.dim;
              rom_sel     <= sel;
              rom_addr    <= base;
              vld_pipe[0] <= 1'b1;
              wa_pipe[0]  <= {1'b0, cs.x};
            end else if (slot == 2'd0) begin
              state <= FIN;
            end else begin
              slot <= slot - 2'd1;
            end
          end
          FETCH: begin
            if (cnt == {3'd0, cur_dim} - 10'd1) begin
              state <= DRAIN;
              cnt   <= '0;
            end else begin
              cnt         <= cnt + 10'd1;
              rom_addr    <= rom_addr + 10'd1;
              vld_pipe[0] <= 1'b1;
              wa_pipe[0]  <= wa_pipe[0] + 11'd1;
            end
          end
          DRAIN: begin
            if (cnt == 10'(ROM_LAT - 1)) begin
              if (slot == 2'd0) begin
                state <= FIN;
              end else begin
                state <= SCAN;
                slot  <= slot - 2'd1;
              end
            end else begin
              cnt <= cnt + 10'd1;
            end
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: per-cycle comparison against a timeline model plus a painter's-algorithm line buffer model.
module tb_sprite_line_scheduler;
  localparam int H = 640;
  localparam int L = 1;
`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, line_start;
  logic [9:0]  line_y;
  logic [31:0] sprite0, sprite1, sprite2;
  logic [9:0]  rom_addr;
  logic [1:0]  rom_sel;
  logic [23:0] rom_data;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [23:0] wr_data;
  logic        busy, done, overrun;

  always #5 clk = ~clk;

  sprite_line_scheduler #(.H_ACTIVE(H), .ROM_LAT(L)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_y(line_y),
    .sprite0(sprite0), .sprite1(sprite1), .sprite2(sprite2),
    .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_data(rom_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .overrun(overrun)
  );

  // ROM model: content is a function of (select, address); one address can be forced black
  logic [10:0] zaddr = 11'h7ff;
  function automatic logic [23:0] rom_fn(input logic [1:0] s, input logic [9:0] a);
    if ({1'b0, a} == zaddr) return 24'h000000;
    return {4'h9, s, 8'h5A, a};
  endfunction

  logic [23:0] rp [L];
  always @(posedge clk) begin
    rp[0] <= rom_fn(rom_sel, rom_addr);
    for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
  end
  assign rom_data = rp[L-1];

  typedef struct {
    bit busy, done, ovr, we, zc, rc, rsc;
    int wa, wd, ra, rs;
  } exp_t;

  exp_t expq[$];
  int   nchk = 0, nerr = 0;
  int   k, done_k, ndone, novr, n_spr_wr, first_spr_wa, last_spr_wa, k1_wa, k1_ovr;
  int   first_spr_wd;
  bit   got_done, last_busy;
  bit   spr_hit [0:1023];
  logic [23:0] spr_val [0:1023];
  logic [23:0] lb [0:1023];
  logic [9:0]  ra_hist [0:2047];
  int   c_ly;
  int   c_dim[3], c_id[3], c_y[3], c_x[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    nchk++;
    if (act !== want) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s k=%0d got=%0h want=%0h", nm, k, act, want);
    end
  endtask

  function automatic logic [31:0] desc(input int dm, input int id, input int y, input int x);
    return {dm[6:0], id[4:0], y[9:0], x[9:0]};
  endfunction

  function automatic bit elig(input int s);
    bit id_ok = (c_id[s] == 0) || (c_id[s] == 2) || (c_id[s] == 3);
    return (c_dim[s] != 0) && id_ok && (c_y[s] <= c_ly) && (c_ly <= c_y[s] + c_dim[s] - 1);
  endfunction

  function automatic int sel_of(input int id);
    return (id == 0) ? 0 : (id == 2) ? 1 : 2;
  endfunction

  // Expected cycle-by-cycle timeline of a whole line
  task automatic build(input bit ovr);
    exp_t e;
    int base, ra, a, d;
    expq.delete();
    for (int i = 0; i < H; i++) begin
      e = '{default:0}; e.busy = 1; e.we = 1; e.wa = i; e.wd = 0; e.ovr = ovr && (i == 0);
      expq.push_back(e);
    end
    for (int s = 2; s >= 0; s--) begin
      e = '{default:0}; e.busy = 1;
      expq.push_back(e);
      if (elig(s)) begin
        base = expq.size();
        for (int c = 0; c < c_dim[s]; c++) begin
          e = '{default:0}; e.busy = 1; e.rc = 1; e.rsc = 1; e.rs = sel_of(c_id[s]);
          e.ra = ((c_ly - c_y[s]) * c_dim[s] + c) % 1024;
          expq.push_back(e);
        end
        for (int j = 0; j < L; j++) begin
          e = '{default:0}; e.busy = 1; e.rsc = 1; e.rs = sel_of(c_id[s]);
          expq.push_back(e);
        end
        for (int c = 0; c < c_dim[s]; c++) begin
          ra = ((c_ly - c_y[s]) * c_dim[s] + c) % 1024;
          a  = c_x[s] + c;
          d  = int'(rom_fn(2'(sel_of(c_id[s])), 10'(ra)));
          if (a < H && !(TRANSP && d == 0)) begin
            e = expq[base + c + L];
            e.we = 1; e.wa = a; e.wd = d;
            expq[base + c + L] = e;
          end
        end
        if (s == 0) break;
      end
    end
    e = '{default:0}; e.done = 1;
    expq.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    @(negedge clk);
    line_start = 1'b0;
    k++;
    e = '{default:0};
    if (expq.size() > 0) e = expq.pop_front();
    chk("busy", busy, e.busy);
    chk("done", done, e.done);
    chk("overrun", overrun, e.ovr);
    chk("wr_en", wr_en, e.we);
    if (e.we || e.zc) begin
      chk("wr_addr", wr_addr, e.wa);
      chk("wr_data", wr_data, e.wd);
    end
    if (e.rc)  chk("rom_addr", rom_addr, e.ra);
    if (e.rsc) chk("rom_sel", rom_sel, e.rs);
    last_busy = e.busy;
    if (wr_en) lb[wr_addr] = wr_data;
    if (wr_en && k > H) begin
      if (n_spr_wr == 0) begin first_spr_wa = wr_addr; first_spr_wd = wr_data; end
      n_spr_wr++; last_spr_wa = wr_addr;
      spr_hit[wr_addr] = 1'b1; spr_val[wr_addr] = wr_data;
    end
    if (k < 2048) ra_hist[k] = rom_addr;
    if (k == 1) begin k1_wa = wr_addr; k1_ovr = overrun; end
    if (done) begin got_done = 1'b1; done_k = k; ndone++; end
    if (overrun) novr++;
  endtask

  task automatic start(input int ly, input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
    logic [31:0] d [3];
    d[0] = s0; d[1] = s1; d[2] = s2;
    line_y = 10'(ly); sprite0 = s0; sprite1 = s1; sprite2 = s2; line_start = 1'b1;
    c_ly = ly;
    for (int s = 0; s < 3; s++) begin
      c_dim[s] = int'(d[s][31:25]); c_id[s] = int'(d[s][24:20]);
      c_y[s]   = int'(d[s][19:10]); c_x[s]  = int'(d[s][9:0]);
    end
    build(last_busy);
    k = 0; got_done = 0; n_spr_wr = 0; first_spr_wa = -1; last_spr_wa = -1; first_spr_wd = -1;
    for (int i = 0; i < 1024; i++) spr_hit[i] = 1'b0;
  endtask

  task automatic rst_cyc(input bit ls);
    exp_t e;
    e = '{default:0}; e.zc = 1; e.rc = 1; e.rsc = 1;
    reset = 1'b1; line_start = ls; line_y = 10'd7;
    expq.delete(); expq.push_back(e);
    cyc();
    reset = 1'b0;
  endtask

  // Painter's algorithm over the latched line, lowest priority first
  task automatic check_linebuf();
    logic [23:0] pb [H];
    int a, ra, bad;
    logic [23:0] d;
    for (int i = 0; i < H; i++) pb[i] = 24'h0;
    for (int s = 2; s >= 0; s--) if (elig(s))
      for (int c = 0; c < c_dim[s]; c++) begin
        a  = c_x[s] + c;
        ra = ((c_ly - c_y[s]) * c_dim[s] + c) % 1024;
        d  = rom_fn(2'(sel_of(c_id[s])), 10'(ra));
        if (a < H && !(TRANSP && d == 24'h0)) pb[a] = d;
      end
    bad = -1;
    for (int i = 0; i < H; i++) if (bad < 0 && lb[i] !== pb[i]) bad = i;
    nchk++;
    if (bad >= 0) begin
      nerr++;
      $display("FAIL linebuf idx=%0d got=%0h want=%0h", bad, lb[bad], pb[bad]);
    end
  endtask

  task automatic run_to_done();
    for (int n = 0; n < 3000 && !got_done; n++) cyc();
    chk("done_seen", got_done, 1'b1);
    if (got_done) check_linebuf();
    repeat (2) cyc();
  endtask

  task automatic rand_start();
    int ly, dm, id, y, off;
    logic [31:0] d [3];
    int ids[5] = '{0, 2, 3, 1, 7};
    ly = int'($urandom_range(0, 1023));
    for (int s = 0; s < 3; s++) begin
      dm  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(1, 40));
      id  = ids[$urandom_range(0, 4)];
      off = int'($urandom_range(0, dm + 4));
      y   = ($urandom_range(0, 3) != 0) ? ((ly - off + 2) & 1023) : int'($urandom_range(0, 1023));
      d[s] = desc(dm, id, y, int'($urandom_range(0, 700)));
    end
    start(ly, d[0], d[1], d[2]);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; line_start = 1'b0; line_y = '0;
    sprite0 = '0; sprite1 = '0; sprite2 = '0;
    k = 0; ndone = 0; novr = 0; last_busy = 0;
    e = '{default:0}; e.zc = 1; e.rc = 1; e.rsc = 1;
    expq.push_back(e);
    cyc();
    rst_cyc(1'b1);            // line_start coincident with reset is ignored
    repeat (3) cyc();

    // Single sprite
    start(105, desc(16, 0, 100, 200), desc(0, 0, 0, 0), desc(16, 1, 100, 0));
    chk("model_len_single", expq.size(), 661);
    run_to_done();
    chk("single_done_k", done_k, 661);
    chk("single_ra_first", ra_hist[644], 80);
    chk("single_ra_last", ra_hist[659], 95);
    chk("single_nwr", n_spr_wr, 16);
    chk("single_wa_first", first_spr_wa, 200);
    chk("single_wa_last", last_spr_wa, 215);

    // Overlap: slot2 paints first, slot0 overwrites
    start(102, desc(8, 0, 100, 300), desc(8, 1, 100, 300), desc(8, 2, 100, 300));
    run_to_done();
    chk("ovl_first_wa", first_spr_wa, 300);
    chk("ovl_first_wd", first_spr_wd, rom_fn(2'd1, 10'd16));
    chk("ovl_lb300", lb[300], rom_fn(2'd0, 10'd16));
    chk("ovl_lb307", lb[307], rom_fn(2'd0, 10'd23));

    // Clipping
    start(100, desc(20, 3, 100, 630), desc(0, 0, 0, 0), desc(0, 0, 0, 0));
    run_to_done();
    chk("clip_nwr", n_spr_wr, 10);
    chk("clip_wa_last", last_spr_wa, 639);
    chk("clip_ra_last", ra_hist[663], 19);
    chk("clip_done_k", done_k, 665);

    // Ineligible slots
    start(99, desc(16, 0, 100, 200), desc(16, 1, 90, 10), desc(0, 0, 99, 10));
    run_to_done();
    chk("inel_done_k", done_k, 644);
    chk("inel_nwr", n_spr_wr, 0);

    // Overrun during FETCH
    ndone = 0; novr = 0;
    start(105, desc(16, 0, 100, 200), desc(0, 0, 0, 0), desc(0, 0, 0, 0));
    for (int n = 0; n < 1000 && k < 646; n++) cyc();
    chk("ovr_reach_fetch", k, 646);
    start(50, desc(4, 2, 50, 20), desc(0, 0, 0, 0), desc(0, 0, 0, 0));
    run_to_done();
    chk("ovr_k1", k1_ovr, 1);
    chk("ovr_k1_wa", k1_wa, 0);
    chk("ovr_pulses", novr, 1);
    chk("ovr_one_done", ndone, 1);

    // Transparency: black ROM word at column 3
    zaddr = 11'd3;
    start(0, desc(8, 0, 0, 50), desc(0, 0, 0, 0), desc(0, 0, 0, 0));
    run_to_done();
    chk("transp_hit53", spr_hit[53], !TRANSP);
    if (!TRANSP) chk("transp_val53", spr_val[53], 24'h0);
    chk("transp_hit52", spr_hit[52], 1'b1);
    zaddr = 11'h7ff;

    // Reset mid-line: no done, no overrun
    ndone = 0; novr = 0;
    start(105, desc(16, 0, 100, 200), desc(0, 0, 0, 0), desc(0, 0, 0, 0));
    repeat (300) cyc();
    rst_cyc(1'b0);
    repeat (5) cyc();
    chk("rst_no_done", ndone, 0);
    chk("rst_no_ovr", novr, 0);

    // Randomized lines with occasional aborts
    for (int t = 0; t < 30; t++) begin
      rand_start();
      if ($urandom_range(0, 4) == 0) begin
        int n;
        n = int'($urandom_range(1, 900));
        for (int i = 0; i < n && !got_done; i++) cyc();
        if (got_done) run_to_done();
        else if ($urandom_range(0, 1) == 0) begin rand_start(); run_to_done(); end
        else begin rst_cyc(1'b0); repeat (2) cyc(); end
      end else begin
        run_to_done();
      end
      repeat ($urandom_range(1, 3)) cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
